writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final stage of the 3-stage RV32I pipeline, directly downstream of the execute stage.
- Consumes the execute stage's wb_* registers and the data-memory read response.
- Formats load data (byte/half select, sign/zero extend) and drives the register-file write port and a bypass to decode.
- Owns the load-wait FSM that raises stall_read to freeze upstream stages while load data is outstanding, and the retired-instruction counter.

Parameters:
- LOAD_TIMEOUT, 16, max cycles spent in WAIT_LOAD before the load is aborted with load_err.
- CNT_W, 64, width of the instret counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- wb_valid  in  1  execute register holds a live instruction this cycle.
- wb_result  in  32  ALU result / link address / load address.
- wb_alu_to_reg  in  1  instruction writes rd.
- wb_mem_to_reg  in  1  instruction is a load.
- wb_dest_reg_sel  in  5  rd index.
- wb_read_address  in  2  load address bits [1:0].
- wb_alu_operation  in  3  funct3 of the instruction.
- dmem_rdata  in  32  data-memory read word.
- dmem_rvalid  in  1  dmem_rdata valid this cycle.
- stall_read  out  1  freeze fetch/execute registers.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write index.
- rf_wdata  out  32  register-file write data.
- fwd_valid  out  1  bypass valid (equals rf_we).
- fwd_reg  out  5  bypass index.
- fwd_data  out  32  bypass data.
- load_err  out  1  one-cycle pulse: misaligned load or timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While reset is asserted, state=IDLE and timeout counter=0. Outputs during reset: stall_read=0, rf_we=0, fwd_valid=0, load_err=0, instret=0, rf_waddr/rf_wdata/fwd_* = 0. Reset mid-WAIT_LOAD abandons the load with no write.
- FSM states:
  - IDLE → WAIT_LOAD: wb_valid & wb_mem_to_reg & !misaligned & !dmem_rvalid.
  - WAIT_LOAD → IDLE: dmem_rvalid (write that cycle), or timeout counter == LOAD_TIMEOUT-1 (load_err pulse, no write).
- stall_read is combinational: 1 in IDLE when a load enters without dmem_rvalid; 1 throughout WAIT_LOAD except in the exit cycle.
- On entry to WAIT_LOAD, capture rd, funct3 and addr[1:0]. In WAIT_LOAD use only the captured copies, never the wb_* inputs.
- Load formatting (funct3, byte lane = addr[1:0]):
  - LB 000 / LBU 100: selected byte, sign- / zero-extended.
  - LH 001 / LHU 101: half selected by addr[1], sign- / zero-extended.
  - LW 010: full word.
  - Other funct3 values: treated as LW.
- Misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]≠0. Result: load_err pulse in the same cycle, no write, no stall, still counts as retired.
- Non-load write: rf_wdata=wb_result, rf_we=wb_valid & wb_alu_to_reg & !wb_mem_to_reg. Zero-cycle latency (combinational from inputs).
- Load write: in the cycle dmem_rvalid is seen (IDLE or WAIT_LOAD).
- rd=x0: rf_we and fwd_valid forced to 0 in all cases.
- instret: +1 on each cycle where an instruction completes (non-load, load write, misaligned, or timeout). Does not increment while stall_read=1. Wraps modulo 2^CNT_W.
- dmem_rvalid in IDLE with no load pending: ignored.

Decomposition:
- Shared pipeline package holds: funct3 load constants (LB, LH, LW, LBU, LHU) and an enum for WB FSM states {IDLE, WAIT_LOAD}.
- One sub-module: load_align (combinational: rdata, addr[1:0], funct3 → formatted data, misaligned flag), reused later by the store-path byte-enable logic.

Test Plan:
1. ALU write: wb_valid=1, alu_to_reg=1, rd=5, result=0x1234_5678 → rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678 same cycle; instret 0→1.
2. LB, addr=2'b11, rdata=0x80FF_0000, rvalid same cycle → rf_wdata=0xFFFF_FF80, stall_read=0. LBU same stimulus → 0x0000_0080.
3. LHU addr=2'b10, rvalid delayed 3 cycles, rdata=0xBEEF_0001 → stall_read=1 for exactly 3 cycles, then rf_wdata=0x0000_BEEF, rf_we=1, captured rd used even though wb_dest_reg_sel is changed during the wait.
4. LW addr=2'b01 → load_err=1 for one cycle, rf_we=0, stall_read=0, instret +1.
5. LW with dmem_rvalid never asserted, LOAD_TIMEOUT=16 → stall_read high 16 cycles, load_err pulse on cycle 16, state returns to IDLE, no write.
6. ALU op with rd=0, result=0xFFFF_FFFF → rf_we=0, fwd_valid=0. Separately, assert reset during WAIT_LOAD → stall_read=0, instret=0, no write on release.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared writeback-stage definitions: load funct3 encodings and load-wait FSM states.
package writeback_stage_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load formatter: selects the byte/half lane, extends it, and flags misaligned accesses.
module load_align
  import writeback_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = rdata_i[7:0];
    case (addr_i)
      2'd0:    byteSel = rdata_i[7:0];
      2'd1:    byteSel = rdata_i[15:8];
      2'd2:    byteSel = rdata_i[23:16];
      default: byteSel = rdata_i[31:24];
    endcase
  end

  assign halfSel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Unrecognised funct3 codes fall through to a full-word load.
  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      LB:      data_o = {{24{byteSel[7]}}, byteSel};
      LBU:     data_o = {24'h0, byteSel};
      LH:      data_o = {{16{halfSel[15]}}, halfSel};
      LHU:     data_o = {16'h0, halfSel};
      default: data_o = rdata_i;
    endcase
  end

  assign misaligned_o = (((funct3_i == LH) || (funct3_i == LHU)) && addr_i[0])
                      || ((funct3_i == LW) && (addr_i != 2'b00));

endmodule

// File: rtl/writeback_stage.sv
// RV32I writeback stage: register-file write/bypass, load formatting, load-wait stall FSM and instret.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [31:0]      wb_result,
  input  logic             wb_alu_to_reg,
  input  logic             wb_mem_to_reg,
  input  logic [4:0]       wb_dest_reg_sel,
  input  logic [1:0]       wb_read_address,
  input  logic [2:0]       wb_alu_operation,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_rvalid,
  output logic             stall_read,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             fwd_valid,
  output logic [4:0]       fwd_reg,
  output logic [31:0]      fwd_data,
  output logic             load_err,
  output logic [CNT_W-1:0] instret
);

  localparam int TW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(LOAD_TIMEOUT - 1);

  wb_state_e        state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [4:0]       capRd_q;
  logic [2:0]       capFunct3_q;
  logic [1:0]       capAddr_q;
  logic [CNT_W-1:0] instret_q;

  logic        inWait, loadIn, ldMis;
  logic [4:0]  ldRd;
  logic [2:0]  ldFunct3;
  logic [1:0]  ldAddr;
  logic [31:0] ldData;
  logic        stallC, writeC, errC, retireC;
  logic [31:0] writeDataC;

  // While waiting, the upstream registers are frozen but may hold stale values, so only captured copies are trusted.
  assign inWait   = (state_q == WAIT_LOAD);
  assign loadIn   = wb_valid & wb_mem_to_reg;
  assign ldRd     = inWait ? capRd_q     : wb_dest_reg_sel;
  assign ldFunct3 = inWait ? capFunct3_q : wb_alu_operation;
  assign ldAddr   = inWait ? capAddr_q   : wb_read_address;

  load_align u_load_align (
    .rdata_i      (dmem_rdata),
    .addr_i       (ldAddr),
    .funct3_i     (ldFunct3),
    .data_o       (ldData),
    .misaligned_o (ldMis)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      capRd_q     <= '0;
      capFunct3_q <= '0;
      capAddr_q   <= '0;
      instret_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (!inWait && (state_d == WAIT_LOAD)) begin
        capRd_q     <= wb_dest_reg_sel;
        capFunct3_q <= wb_alu_operation;
        capAddr_q   <= wb_read_address;
      end
      if (retireC && !stallC) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (loadIn && !ldMis && !dmem_rvalid) begin
          state_d = WAIT_LOAD;
          timer_d = '0;
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid || (timer_q == TIMER_LAST)) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stallC     = 1'b0;
    writeC     = 1'b0;
    errC       = 1'b0;
    retireC    = 1'b0;
    writeDataC = ldData;
    case (state_q)
      IDLE: begin
        if (loadIn) begin
          if (ldMis) begin
            errC    = 1'b1;
            retireC = 1'b1;
          end else if (dmem_rvalid) begin
            writeC  = 1'b1;
            retireC = 1'b1;
          end else begin
            stallC  = 1'b1;
          end
        end else if (wb_valid) begin
          writeC     = wb_alu_to_reg;
          writeDataC = wb_result;
          retireC    = 1'b1;
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          writeC  = 1'b1;
          retireC = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          errC    = 1'b1;
          retireC = 1'b1;
        end else begin
          stallC  = 1'b1;
        end
      end
      default: ;
    endcase
    if (ldRd == 5'd0) begin
      writeC = 1'b0;
    end
  end

  // Outputs are forced quiet while reset is held, regardless of what upstream presents.
  assign stall_read = stallC & ~reset;
  assign rf_we      = writeC & ~reset;
  assign rf_waddr   = rf_we ? ldRd : 5'd0;
  assign rf_wdata   = rf_we ? writeDataC : 32'd0;
  assign fwd_valid  = rf_we;
  assign fwd_reg    = rf_waddr;
  assign fwd_data   = rf_wdata;
  assign load_err   = errC & ~reset;
  assign instret    = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomised scoreboard bench for writeback_stage: a transaction-level model predicts every cycle's outputs.
module tb_writeback_stage;

  localparam int LOAD_TIMEOUT = 16;
  localparam int CNT_W        = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             wb_valid;
  logic [31:0]      wb_result;
  logic             wb_alu_to_reg;
  logic             wb_mem_to_reg;
  logic [4:0]       wb_dest_reg_sel;
  logic [1:0]       wb_read_address;
  logic [2:0]       wb_alu_operation;
  logic [31:0]      dmem_rdata;
  logic             dmem_rvalid;
  logic             stall_read;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             fwd_valid;
  logic [4:0]       fwd_reg;
  logic [31:0]      fwd_data;
  logic             load_err;
  logic [CNT_W-1:0] instret;

  writeback_stage #(.LOAD_TIMEOUT(LOAD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .wb_valid         (wb_valid),
    .wb_result        (wb_result),
    .wb_alu_to_reg    (wb_alu_to_reg),
    .wb_mem_to_reg    (wb_mem_to_reg),
    .wb_dest_reg_sel  (wb_dest_reg_sel),
    .wb_read_address  (wb_read_address),
    .wb_alu_operation (wb_alu_operation),
    .dmem_rdata       (dmem_rdata),
    .dmem_rvalid      (dmem_rvalid),
    .stall_read       (stall_read),
    .rf_we            (rf_we),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .fwd_valid        (fwd_valid),
    .fwd_reg          (fwd_reg),
    .fwd_data         (fwd_data),
    .load_err         (load_err),
    .instret          (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              stall;
    bit              we;
    logic [4:0]      waddr;
    logic [31:0]     wdata;
    bit              err;
    longint unsigned instret;
  } exp_t;

  exp_t            expQ[$];
  int              vectors     = 0;
  int              miscompares = 0;
  longint unsigned retired     = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input bit stall, input bit we, input logic [4:0] waddr,
                         input logic [31:0] wdata, input bit err);
    exp_t e;
    e.stall   = stall;
    e.we      = we;
    e.waddr   = waddr;
    e.wdata   = wdata;
    e.err     = err;
    e.instret = retired;
    expQ.push_back(e);
  endtask

  // Load result computed from the byte-lane rules with plain shift/mask arithmetic.
  function automatic logic [31:0] refFormat(input logic [2:0] f3, input logic [1:0] addr,
                                            input logic [31:0] rdata);
    int unsigned a = addr;
    int unsigned b;
    int unsigned h;
    b = (rdata >> (8 * a)) & 32'hFF;
    h = (rdata >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b101:  return h;
      default: return rdata;
    endcase
  endfunction

  function automatic bit refMisaligned(input logic [2:0] f3, input logic [1:0] addr);
    int unsigned a = addr;
    if ((f3 == 3'b001 || f3 == 3'b101) && (a % 2 != 0)) return 1'b1;
    if (f3 == 3'b010 && a != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic scrambleWb();
    wb_valid         = 1'($urandom_range(0, 1));
    wb_result        = $urandom();
    wb_alu_to_reg    = 1'($urandom_range(0, 1));
    wb_mem_to_reg    = 1'($urandom_range(0, 1));
    wb_dest_reg_sel  = 5'($urandom_range(0, 31));
    wb_read_address  = 2'($urandom_range(0, 3));
    wb_alu_operation = 3'($urandom_range(0, 7));
  endtask

  // kind: 0 = bubble, 1 = non-load, 2 = load; lat = cycles until dmem_rvalid (beyond the timeout means never).
  task automatic applyStimulus(input int kind, input logic aluToReg, input logic [4:0] rd,
                               input logic [31:0] result, input logic [2:0] f3,
                               input logic [1:0] addr, input logic [31:0] rdata, input int lat);
    @(posedge clk); #1;
    wb_valid         = (kind != 0);
    wb_mem_to_reg    = (kind == 2);
    wb_alu_to_reg    = aluToReg;
    wb_dest_reg_sel  = rd;
    wb_result        = result;
    wb_alu_operation = f3;
    wb_read_address  = addr;
    dmem_rdata       = $urandom();
    dmem_rvalid      = 1'b0;
    if (kind == 0) begin
      dmem_rvalid = 1'($urandom_range(0, 1));
      pushExp(0, 0, 0, 0, 0);
    end else if (kind == 1) begin
      dmem_rvalid = 1'($urandom_range(0, 1));
      pushExp(0, aluToReg && (rd != 0), rd, result, 0);
      retired++;
    end else if (refMisaligned(f3, addr)) begin
      dmem_rvalid = 1'($urandom_range(0, 1));
      pushExp(0, 0, 0, 0, 1);
      retired++;
    end else begin
      for (int k = 0; k <= LOAD_TIMEOUT; k++) begin
        if (k > 0) begin
          @(posedge clk); #1;
          scrambleWb();
          dmem_rdata = $urandom();
        end
        dmem_rvalid = (k == lat);
        if (k == lat) begin
          dmem_rdata = rdata;
          pushExp(0, rd != 0, rd, refFormat(f3, addr, rdata), 0);
          retired++;
          break;
        end else if (k == LOAD_TIMEOUT) begin
          pushExp(0, 0, 0, 0, 1);
          retired++;
        end else begin
          pushExp(1, 0, 0, 0, 0);
        end
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("stall_read", 64'(stall_read), 64'(e.stall));
        checkOutput("rf_we",      64'(rf_we),      64'(e.we));
        checkOutput("fwd_valid",  64'(fwd_valid),  64'(e.we));
        checkOutput("load_err",   64'(load_err),   64'(e.err));
        checkOutput("instret",    64'(instret),    64'(e.instret));
        if (e.we) begin
          checkOutput("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
          checkOutput("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
          checkOutput("fwd_reg",  64'(fwd_reg),  64'(e.waddr));
          checkOutput("fwd_data", 64'(fwd_data), 64'(e.wdata));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] f3Table [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    int         kind;
    int         lat;
    int         pick;

    reset = 1'b1;
    wb_valid = 0; wb_result = 0; wb_alu_to_reg = 0; wb_mem_to_reg = 0;
    wb_dest_reg_sel = 0; wb_read_address = 0; wb_alu_operation = 0;
    dmem_rdata = 0; dmem_rvalid = 0;
    repeat (2) begin
      @(posedge clk); #1;
      pushExp(0, 0, 0, 0, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    pushExp(0, 0, 0, 0, 0);

    $display("[TB] directed sequence");
    applyStimulus(1, 1, 5'd5,  32'h1234_5678, 3'b000, 2'b00, 32'h0, 0);
    applyStimulus(2, 0, 5'd7,  32'h0, 3'b000, 2'b11, 32'h80FF_0000, 0);
    applyStimulus(2, 0, 5'd8,  32'h0, 3'b100, 2'b11, 32'h80FF_0000, 0);
    applyStimulus(2, 0, 5'd9,  32'h0, 3'b101, 2'b10, 32'hBEEF_0001, 3);
    applyStimulus(2, 0, 5'd10, 32'h0, 3'b010, 2'b01, 32'h0, 0);
    applyStimulus(2, 0, 5'd11, 32'h0, 3'b010, 2'b00, 32'hDEAD_BEEF, 100);
    applyStimulus(2, 0, 5'd12, 32'h0, 3'b010, 2'b00, 32'hCAFE_F00D, LOAD_TIMEOUT);
    applyStimulus(1, 1, 5'd0,  32'hFFFF_FFFF, 3'b000, 2'b00, 32'h0, 0);
    applyStimulus(0, 0, 5'd0,  32'h0, 3'b000, 2'b00, 32'h0, 0);

    $display("[TB] reset during load wait");
    @(posedge clk); #1;
    wb_valid = 1; wb_mem_to_reg = 1; wb_alu_to_reg = 0; wb_dest_reg_sel = 5'd13;
    wb_alu_operation = 3'b010; wb_read_address = 2'b00; dmem_rvalid = 0;
    pushExp(1, 0, 0, 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
      scrambleWb();
      dmem_rvalid = 0;
      pushExp(1, 0, 0, 0, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    wb_valid = 0; dmem_rvalid = 0;
    retired = 0;
    pushExp(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    dmem_rvalid = 1; dmem_rdata = 32'h5555_AAAA;
    pushExp(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 5'd0, 32'h0, 3'b000, 2'b00, 32'h0, 0);

    $display("[TB] random sequence");
    for (int n = 0; n < 400; n++) begin
      pick = $urandom_range(0, 99);
      kind = (pick < 15) ? 0 : (pick < 55) ? 1 : 2;
      pick = $urandom_range(0, 99);
      lat  = (pick < 50) ? 0 : (pick < 88) ? $urandom_range(1, 5)
           : (pick < 92) ? LOAD_TIMEOUT : $urandom_range(LOAD_TIMEOUT + 1, LOAD_TIMEOUT + 4);
      applyStimulus(kind, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                    f3Table[$urandom_range(0, 4)], 2'($urandom_range(0, 3)), $urandom(), lat);
    end
    applyStimulus(0, 0, 5'd0, 32'h0, 3'b000, 2'b00, 32'h0, 0);

    repeat (3) @(posedge clk);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
